mcu_local_bram_loader: RTL and testbench

- Upstream neighbour of the local BRAM reader FSM.
- Accepts one AXI-Stream burst of coefficient/data words and writes them sequentially into the local BRAM, starting at address 0, through the BRAM write-port control interface.
- Sequenced by the global MCU FSM.
- Reports completion (`load_done`) or a length/protocol mismatch (`error`), so the global FSM only enters GLO_FSM_STR, the reader's start state, once the BRAM holds a complete image.

---
 rtl/mcu_local_bram_loader_pkg.sv | 29 ++
 rtl/mcu_local_bram_loader.sv | 113 +++++++++++
 tb/tb_mcu_local_bram_loader.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mcu_local_bram_loader_pkg.sv
// Shared encodings for the local BRAM loader: global MCU FSM states it decodes
// and its own local state type.
package mcu_local_bram_loader_pkg;

  // Global MCU FSM encoding; mirrors header_MCUGlobalFSMParameters.vh with LOD added.
  localparam int GLO_FSM_WIDTH = 3;
  localparam logic [GLO_FSM_WIDTH-1:0] GLO_FSM_IDLE = 3'd0;
  localparam logic [GLO_FSM_WIDTH-1:0] GLO_FSM_LOD  = 3'd1;
  localparam logic [GLO_FSM_WIDTH-1:0] GLO_FSM_STR  = 3'd2;
  localparam logic [GLO_FSM_WIDTH-1:0] GLO_FSM_END  = 3'd3;
  localparam logic [GLO_FSM_WIDTH-1:0] GLO_FSM_ERR  = 3'd4;

`ifdef USE_ONE_HOT_ENCODING_FSM
  typedef enum logic [3:0] {
    LDR_FSM_IDLE = 4'b0001,
    LDR_FSM_LOAD = 4'b0010,
    LDR_FSM_DONE = 4'b0100,
    LDR_FSM_ERR  = 4'b1000
  } ldr_state_t;
`else
  typedef enum logic [1:0] {
    LDR_FSM_IDLE = 2'd0,
    LDR_FSM_LOAD = 2'd1,
    LDR_FSM_DONE = 2'd2,
    LDR_FSM_ERR  = 2'd3
  } ldr_state_t;
`endif

endpackage

// File: rtl/mcu_local_bram_loader.sv
// Loads one AXI-Stream burst into local BRAM from address 0 and flags
// completion or a length/protocol mismatch to the global MCU FSM.
module mcu_local_bram_loader
  import mcu_local_bram_loader_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int DATA_STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [DATA_STRB_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic                       bram_en,
  output logic [DATA_STRB_WIDTH-1:0] bram_we,
  output logic [ADDR_WIDTH-1:0]      bram_addr,
  output logic [DATA_WIDTH-1:0]      bram_wrdata,
  input  logic [GLO_FSM_WIDTH-1:0]   glo_fsm_state,
  input  logic [ADDR_WIDTH:0]        addr_counter_max,
  output logic [ADDR_WIDTH:0]        words_written,
  output logic                       load_done,
  output logic                       error
);

  ldr_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] max_reg;
  logic [ADDR_WIDTH-1:0] addr_cnt;
  logic [ADDR_WIDTH:0]   max_m1;
  logic                  in_load;
  logic                  hs;
  logic                  last_addr;
  logic                  load_start;

  // A BRAM write always completes in one cycle, so LOAD never backpressures.
  assign in_load       = (state == LDR_FSM_LOAD);
  assign s_axis_tready = in_load;
  assign hs            = s_axis_tvalid && in_load;
  assign last_addr     = (addr_cnt == max_reg);
  assign max_m1        = addr_counter_max - (ADDR_WIDTH+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LDR_FSM_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_done  = 1'b0;
    error      = 1'b0;
    load_start = 1'b0;
    case (state)
      LDR_FSM_IDLE: begin
        if (glo_fsm_state == GLO_FSM_LOD) begin
          if (addr_counter_max == '0) begin
            state_nxt = LDR_FSM_ERR;
          end else begin
            state_nxt  = LDR_FSM_LOAD;
            load_start = 1'b1;
          end
        end
      end
      LDR_FSM_LOAD: begin
        // Global abort wins; a beat accepted on the same edge is still written.
        if (glo_fsm_state == GLO_FSM_ERR)
          state_nxt = LDR_FSM_IDLE;
        else if (hs && (last_addr || s_axis_tlast))
          state_nxt = (last_addr && s_axis_tlast) ? LDR_FSM_DONE : LDR_FSM_ERR;
      end
      LDR_FSM_DONE: begin
        load_done = 1'b1;
        if (glo_fsm_state == GLO_FSM_END || glo_fsm_state == GLO_FSM_ERR)
          state_nxt = LDR_FSM_IDLE;
      end
      LDR_FSM_ERR: begin
        error = 1'b1;
        if (glo_fsm_state == GLO_FSM_ERR)
          state_nxt = LDR_FSM_IDLE;
      end
      default: state_nxt = LDR_FSM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_en       <= 1'b0;
      bram_we       <= '0;
      bram_addr     <= '0;
      bram_wrdata   <= '0;
      max_reg       <= '0;
      addr_cnt      <= '0;
      words_written <= '0;
    end else begin
      bram_en <= hs;
      bram_we <= hs ? s_axis_tkeep : '0;
      if (load_start) begin
        max_reg       <= max_m1[ADDR_WIDTH-1:0];
        addr_cnt      <= '0;
        words_written <= '0;
      end else if (hs) begin
        bram_addr     <= addr_cnt;
        bram_wrdata   <= s_axis_tdata;
        words_written <= words_written + (ADDR_WIDTH+1)'(1);
        // Hold on the terminal beat so a full 2^ADDR_WIDTH load cannot wrap.
        if (!last_addr) addr_cnt <= addr_cnt + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mcu_local_bram_loader.sv
// Bench for mcu_local_bram_loader: table of load scenarios, random loads and
// hand-built abort/reset sequences, all checked against a beat-counting model.
module tb_mcu_local_bram_loader;
  import mcu_local_bram_loader_pkg::*;

  localparam int DW = 16;
  localparam int SW = 2;
  localparam int AW = 32;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [DW-1:0]            tdata;
  logic [SW-1:0]            tkeep;
  logic                     tvalid;
  logic                     tready;
  logic                     tlast;
  logic                     bram_en;
  logic [SW-1:0]            bram_we;
  logic [AW-1:0]            bram_addr;
  logic [DW-1:0]            bram_wrdata;
  logic [GLO_FSM_WIDTH-1:0] glo;
  logic [AW:0]              acm;
  logic [AW:0]              words_written;
  logic                     load_done;
  logic                     error;

  mcu_local_bram_loader #(.DATA_WIDTH(DW), .DATA_STRB_WIDTH(SW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
    .s_axis_tready(tready), .s_axis_tlast(tlast),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
    .glo_fsm_state(glo), .addr_counter_max(acm), .words_written(words_written),
    .load_done(load_done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a load accepts beats until `max` have been taken or tlast arrives;
  // beat n lands at address n one cycle after it is accepted.
  bit            m_load, m_done, m_err;
  int            m_max, m_cnt;
  bit            p_en;
  logic [SW-1:0] p_we;
  int            p_addr;
  logic [DW-1:0] p_data;

  task automatic model_reset();
    m_load = 0; m_done = 0; m_err = 0; m_max = 0; m_cnt = 0;
    p_en = 0; p_we = '0; p_addr = 0; p_data = '0;
  endtask

  task automatic step(input logic [GLO_FSM_WIDTH-1:0] g, input bit v,
                      input logic [DW-1:0] d, input logic [SW-1:0] k, input bit l);
    bit hsm;
    @(negedge clk);
    chk("tready", tready, m_load);
    chk("load_done", load_done, m_done);
    chk("error", error, m_err);
    chk("bram_en", bram_en, p_en);
    chk("bram_we", bram_we, p_en ? p_we : '0);
    if (p_en) begin
      chk("bram_addr", bram_addr, p_addr);
      chk("bram_wrdata", bram_wrdata, p_data);
    end
    chk("words_written", words_written, m_cnt);
    glo = g; tvalid = v; tdata = d; tkeep = k; tlast = l;
    hsm  = v && m_load;
    p_en = hsm;
    if (hsm) begin
      p_we = k; p_addr = m_cnt; p_data = d; m_cnt++;
    end
    if (m_load) begin
      if (g == GLO_FSM_ERR) m_load = 0;
      else if (hsm && (m_cnt == m_max || l)) begin
        m_load = 0;
        m_done = (m_cnt == m_max) && l;
        m_err  = !m_done;
      end
    end else if (m_done) begin
      if (g == GLO_FSM_END || g == GLO_FSM_ERR) m_done = 0;
    end else if (m_err) begin
      if (g == GLO_FSM_ERR) m_err = 0;
    end else if (g == GLO_FSM_LOD) begin
      if (acm == '0) m_err = 1;
      else begin
        m_load = 1; m_max = int'(acm); m_cnt = 0;
      end
    end
  endtask

  task automatic idle_step();
    step(GLO_FSM_IDLE, 1'b0, '0, '0, 1'b0);
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random bubbles
  task automatic run_load(input int max, input int n_offer, input int last_idx,
                          input int mode, input int strb_idx, input logic [DW-1:0] base);
    int b = 0;
    int cyc = 0;
    bit v, pre;
    acm = (AW+1)'(max);
    step(GLO_FSM_LOD, 1'b1, base, 2'b11, 1'b0);   // offered before tready: must be ignored
    while (m_load && cyc < 300) begin
      v = (b < n_offer) && (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                            (mode == 2 && $urandom_range(0, 3) != 0));
      pre = v && m_load;
      step(GLO_FSM_IDLE, v, base + DW'(b), (b == strb_idx) ? 2'b01 : 2'b11, b == last_idx);
      if (pre) b++;
      cyc++;
    end
    chk("load_timeout", m_load, 1'b0);
    for (int e = 0; e < 3; e++)
      step(GLO_FSM_IDLE, b < n_offer, base + DW'(b), 2'b11, 1'b0);
  endtask

  task automatic exit_load();
    if (m_done) step(GLO_FSM_END, 1'b0, '0, '0, 1'b0);
    else        step(GLO_FSM_ERR, 1'b0, '0, '0, 1'b0);
    idle_step();
    chk("exit_idle_done", load_done, 1'b0);
    chk("exit_idle_err", error, 1'b0);
  endtask

  typedef struct {
    int max; int n_offer; int last_idx; int mode; int strb_idx;
    int exp_words; bit exp_done; bit exp_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int max, kind, last, n, exp_w;
    tbl[0] = '{0, 0, -1, 0, -1, 0, 1'b0, 1'b1};  // zero length
    tbl[1] = '{8, 8,  7, 0, -1, 8, 1'b1, 1'b0};  // nominal
    tbl[2] = '{8, 8,  7, 1,  2, 8, 1'b1, 1'b0};  // bubbles, partial strobe on beat 3
    tbl[3] = '{4, 2,  1, 0, -1, 2, 1'b0, 1'b1};  // short stream
    tbl[4] = '{4, 5, -1, 0, -1, 4, 1'b0, 1'b1};  // long stream, 5th beat refused
    tbl[5] = '{1, 1,  0, 0, -1, 1, 1'b1, 1'b0};  // single word
    tbl[6] = '{1, 2, -1, 0, -1, 1, 1'b0, 1'b1};  // single word, no tlast

    rst = 1'b1; glo = GLO_FSM_IDLE; acm = '0;
    tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst_tready", tready, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_bram_we", bram_we, 0);
    chk("rst_bram_addr", bram_addr, 0);
    chk("rst_bram_wrdata", bram_wrdata, 0);
    chk("rst_words", words_written, 0);
    chk("rst_done", load_done, 0);
    chk("rst_error", error, 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_load(tbl[i].max, tbl[i].n_offer, tbl[i].last_idx, tbl[i].mode, tbl[i].strb_idx, 16'h1000);
      chk($sformatf("tbl%0d_words", i), words_written, tbl[i].exp_words);
      chk($sformatf("tbl%0d_done", i), load_done, tbl[i].exp_done);
      chk($sformatf("tbl%0d_error", i), error, tbl[i].exp_err);
      chk($sformatf("tbl%0d_tready", i), tready, 0);
      exit_load();
    end

    for (int r = 0; r < 20; r++) begin
      max  = int'($urandom_range(1, 10));
      kind = int'($urandom_range(0, 2));
      case (kind)
        0:       begin last = max - 1; n = max; exp_w = max; end
        1:       begin last = int'($urandom_range(0, max - 1)); n = last + 1; exp_w = last + 1; end
        default: begin last = -1; n = max + 1; exp_w = max; end
      endcase
      run_load(max, n, last, 2, int'($urandom_range(0, 9)), DW'($urandom));
      chk("rand_words", words_written, exp_w);
      chk("rand_done", load_done, last == max - 1);
      exit_load();
    end

    // Global abort during LOAD with a beat accepted on the same edge.
    acm = 4;
    step(GLO_FSM_LOD, 1'b0, '0, '0, 1'b0);
    step(GLO_FSM_IDLE, 1'b1, 16'hA000, 2'b11, 1'b0);
    step(GLO_FSM_ERR, 1'b1, 16'hA001, 2'b11, 1'b0);
    idle_step();
    chk("abort_load_tready", tready, 0);
    chk("abort_load_en", bram_en, 1);
    chk("abort_load_addr", bram_addr, 1);
    chk("abort_load_error", error, 0);
    idle_step();

    // Global abort while DONE.
    acm = 1;
    step(GLO_FSM_LOD, 1'b0, '0, '0, 1'b0);
    step(GLO_FSM_IDLE, 1'b1, 16'hB000, 2'b11, 1'b1);
    idle_step();
    chk("abort_done_pre", load_done, 1);
    step(GLO_FSM_ERR, 1'b0, '0, '0, 1'b0);
    idle_step();
    chk("abort_done_post", load_done, 0);

    // Async reset between edges after 3 of 8 beats, then a fresh 2-word load.
    acm = 8;
    step(GLO_FSM_LOD, 1'b0, '0, '0, 1'b0);
    for (int j = 0; j < 3; j++) step(GLO_FSM_IDLE, 1'b1, 16'hC000 + DW'(j), 2'b11, 1'b0);
    idle_step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_tready", tready, 0);
    chk("midrst_bram_en", bram_en, 0);
    chk("midrst_bram_we", bram_we, 0);
    chk("midrst_bram_addr", bram_addr, 0);
    chk("midrst_bram_wrdata", bram_wrdata, 0);
    chk("midrst_words", words_written, 0);
    chk("midrst_done", load_done, 0);
    chk("midrst_error", error, 0);
    rst = 1'b0;
    model_reset();
    run_load(2, 2, 1, 0, -1, 16'hD000);
    chk("postrst_words", words_written, 2);
    chk("postrst_done", load_done, 1);
    exit_load();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
